sevenseg_capture: RTL and testbench

Receive-side monitor for the multiplexed seven-segment display bus. It samples the active-low segment lines and active-low digit anodes, and waits for each pattern to be stable. It then decodes the pattern back into the 4-bit digit code, stores one code per display position, and pulses when a full scan frame has been captured. The block sits on the board-facing display pins in loopback and test builds, so the digit values driven by the display path can be checked in hardware and in simulation.

---
 rtl/sevenseg_capture.sv | 209 ++++++++++++++++++++
 tb/tb_sevenseg_capture.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_capture.sv
// Receive-side monitor for the multiplexed seven-segment bus: debounces each
// (anodes, segments) dwell, decodes it to a digit code per position and flags
// complete scan frames. Define SEVENSEG_CAPTURE_ERRCNT_EN to add the err_count output.
module sevenseg_capture #(
  parameter int unsigned NDIGITS       = 4,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             segments,
  input  logic [NDIGITS-1:0]     anodes,
  output logic [4*NDIGITS-1:0]   digits,
  output logic                   frame_valid,
  output logic                   decode_err
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
  ,
  output logic [7:0]             err_count
`endif
);

  localparam int unsigned SMP_W   = NDIGITS + 8;
  localparam logic [7:0]  CNT_MAX = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURED
  } state_t;

  typedef enum logic [1:0] {
    AN_BLANK,
    AN_VALID,
    AN_ILLEGAL
  } an_class_t;

  // Count low anode bits: none = blanking, one = a position, more = illegal.
  function automatic an_class_t classify(input logic [NDIGITS-1:0] an);
    int unsigned n_low;
    n_low = 0;
    for (int i = 0; i < int'(NDIGITS); i++) begin
      if (!an[i]) n_low++;
    end
    if (n_low == 0)      return AN_BLANK;
    else if (n_low == 1) return AN_VALID;
    else                 return AN_ILLEGAL;
  endfunction

  // Returns {known, code}; unknown patterns report known = 0.
  function automatic logic [4:0] decode(input logic [7:0] seg);
    case (seg)
      8'hC0:   return {1'b1, 4'h0};
      8'hF9:   return {1'b1, 4'h1};
      8'hA4:   return {1'b1, 4'h2};
      8'hB0:   return {1'b1, 4'h3};
      8'h99:   return {1'b1, 4'h4};
      8'h92:   return {1'b1, 4'h5};
      8'h82:   return {1'b1, 4'h6};
      8'hF8:   return {1'b1, 4'h7};
      8'h80:   return {1'b1, 4'h8};
      8'h7F:   return {1'b1, 4'hF};
      default: return {1'b0, 4'hF};
    endcase
  endfunction

  logic [SMP_W-1:0]    r_sync1;
  logic [SMP_W-1:0]    r_sync2;
  logic [SMP_W-1:0]    r_cmp;
  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_cnt;
  logic [7:0]          w_cnt_nxt;
  logic [NDIGITS-1:0]  r_mask;
  logic [4*NDIGITS-1:0] r_digits;
  logic                r_frame_valid;
  logic                r_decode_err;

  logic [NDIGITS-1:0]  w_an;
  logic [7:0]          w_seg;
  an_class_t           w_cls;
  an_class_t           w_prev_cls;
  logic                w_same;
  logic                w_capture;
  logic [4:0]          w_dec;
  logic [NDIGITS-1:0]  w_mask_set;
  logic                w_frame_done;
  logic                w_ill_entry;
  logic                w_err_nxt;

  // Input synchronizer plus the previous-sample compare register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_cmp   <= '1;
    end else begin
      r_sync1 <= {anodes, segments};
      r_sync2 <= r_sync1;
      r_cmp   <= r_sync2;
    end
  end

  assign w_an       = r_sync2[SMP_W-1:8];
  assign w_seg      = r_sync2[7:0];
  assign w_cls      = classify(w_an);
  assign w_prev_cls = classify(r_cmp[SMP_W-1:8]);
  assign w_same     = (r_sync2 == r_cmp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture fires on the sample after cnt has reached STABLE_CYCLES, so cnt saturates.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cls == AN_VALID) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = 8'd1;
        end
      end
      S_SETTLE: begin
        if (w_cls != AN_VALID) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end else if (!w_same) begin
          w_cnt_nxt   = 8'd1;
        end else if (r_cnt >= CNT_MAX) begin
          w_capture   = 1'b1;
          w_state_nxt = S_CAPTURED;
        end else begin
          w_cnt_nxt   = r_cnt + 8'd1;
        end
      end
      S_CAPTURED: begin
        if (!w_same) begin
          if (w_cls == AN_VALID) begin
            w_state_nxt = S_SETTLE;
            w_cnt_nxt   = 8'd1;
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // A valid anode sample is one-hot low, so its inverse is the position's mask bit.
  always_comb begin
    w_dec        = decode(w_seg);
    w_mask_set   = r_mask | ~w_an;
    w_frame_done = w_capture && (w_mask_set == {NDIGITS{1'b1}});
    w_ill_entry  = (w_cls == AN_ILLEGAL) && (w_prev_cls != AN_ILLEGAL);
    w_err_nxt    = (w_capture && !w_dec[4]) || w_ill_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask        <= '0;
      r_digits      <= '1;
      r_frame_valid <= 1'b0;
      r_decode_err  <= 1'b0;
    end else begin
      r_frame_valid <= w_frame_done;
      r_decode_err  <= w_err_nxt;
      if (w_capture) begin
        r_mask <= w_frame_done ? '0 : w_mask_set;
      end
      for (int i = 0; i < int'(NDIGITS); i++) begin
        if (w_capture && w_dec[4] && !w_an[i]) begin
          r_digits[4*i +: 4] <= w_dec[3:0];
        end
      end
    end
  end

`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
  logic [7:0] r_err_count;

  // Saturating count of decode_err pulses; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_count <= 8'd0;
    end else if (w_err_nxt && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`endif

  assign digits      = r_digits;
  assign frame_valid = r_frame_valid;
  assign decode_err  = r_decode_err;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture: capture latency, frame pulses, glitch,
// unknown-pattern and illegal-anode handling, reset in mid-frame.
module tb_sevenseg_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  segments;
  logic [3:0]  anodes;
  logic [15:0] digits;
  logic        frame_valid;
  logic        decode_err;
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int fv_seen = 0;
  int err_seen = 0;
  int five_seen = 0;

  always #5 clk = ~clk;

  sevenseg_capture #(
    .NDIGITS       (4),
    .STABLE_CYCLES (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .segments    (segments),
    .anodes      (anodes),
    .digits      (digits),
    .frame_valid (frame_valid),
    .decode_err  (decode_err)
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  // Pulse and value observer, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_valid) fv_seen++;
      if (decode_err) err_seen++;
      if (digits[7:4] == 4'h5) five_seen++;
    end
  end

  task automatic hold(input logic [3:0] an, input logic [7:0] sg, input int n);
    anodes   = an;
    segments = sg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic blank(input int n);
    hold(4'hF, 8'hFF, n);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    anodes   = 4'hF;
    segments = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    anodes   = 4'hF;
    segments = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (digits !== 16'hFFFF) begin
      n_bad++; $display("FAIL reset_digits: got %h want %h", digits, 16'hFFFF);
    end
    n_vec++;
    if (frame_valid !== 1'b0 || decode_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_pulses: got fv=%b err=%b want 0 0", frame_valid, decode_err);
    end
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
    n_vec++;
    if (err_count !== 8'd0) begin
      n_bad++; $display("FAIL reset_errcount: got %0d want 0", err_count);
    end
`endif
    reset = 1'b0;
    blank(2);
  endtask

  task automatic test_basic();
    int fb, eb;
    fb = fv_seen;
    eb = err_seen;
    hold(4'b1110, 8'hA4, 5);
    n_vec++;
    if (digits[3:0] !== 4'hF) begin
      n_bad++; $display("FAIL basic_early: got %h want %h", digits[3:0], 4'hF);
    end
    hold(4'b1110, 8'hA4, 1);
    n_vec++;
    if (digits[3:0] !== 4'h2) begin
      n_bad++; $display("FAIL basic_latency: got %h want %h", digits[3:0], 4'h2);
    end
    hold(4'b1110, 8'hA4, 4);
    blank(2);
    n_vec++;
    if (fv_seen - fb !== 0 || err_seen - eb !== 0) begin
      n_bad++; $display("FAIL basic_pulses: got fv=%0d err=%0d want 0 0", fv_seen - fb, err_seen - eb);
    end
  endtask

  task automatic test_full_scan();
    int fb;
    do_reset();
    fb = fv_seen;
    hold(4'b1110, 8'hC0, 8); blank(2);
    hold(4'b1101, 8'hF9, 8); blank(2);
    hold(4'b1011, 8'h80, 8); blank(2);
    hold(4'b0111, 8'h7F, 5);
    n_vec++;
    if (frame_valid !== 1'b0) begin
      n_bad++; $display("FAIL scan_fv_early: got %b want 0", frame_valid);
    end
    hold(4'b0111, 8'h7F, 1);
    n_vec++;
    if (frame_valid !== 1'b1) begin
      n_bad++; $display("FAIL scan_fv_pulse: got %b want 1", frame_valid);
    end
    hold(4'b0111, 8'h7F, 1);
    n_vec++;
    if (frame_valid !== 1'b0) begin
      n_bad++; $display("FAIL scan_fv_width: got %b want 0", frame_valid);
    end
    hold(4'b0111, 8'h7F, 1);
    blank(2);
    n_vec++;
    if (digits !== 16'hF810) begin
      n_bad++; $display("FAIL scan_digits: got %h want %h", digits, 16'hF810);
    end
    n_vec++;
    if (fv_seen - fb !== 1) begin
      n_bad++; $display("FAIL scan_fv_count: got %0d want 1", fv_seen - fb);
    end
  endtask

  task automatic test_glitch();
    int f5;
    f5 = five_seen;
    hold(4'b1101, 8'h92, 2);
    hold(4'b1101, 8'h82, 8);
    blank(2);
    n_vec++;
    if (digits[7:4] !== 4'h6) begin
      n_bad++; $display("FAIL glitch_digit: got %h want %h", digits[7:4], 4'h6);
    end
    n_vec++;
    if (five_seen - f5 !== 0) begin
      n_bad++; $display("FAIL glitch_no5: got %0d cycles with 5 want 0", five_seen - f5);
    end
  endtask

  task automatic test_unknown();
    int eb;
    eb = err_seen;
    hold(4'b1011, 8'h00, 8);
    blank(2);
    n_vec++;
    if (err_seen - eb !== 1) begin
      n_bad++; $display("FAIL unknown_err: got %0d pulses want 1", err_seen - eb);
    end
    n_vec++;
    if (digits[11:8] !== 4'h8) begin
      n_bad++; $display("FAIL unknown_keep: got %h want %h", digits[11:8], 4'h8);
    end
  endtask

  task automatic test_err_mask();
    int fb;
    fb = fv_seen;
    hold(4'b1110, 8'hF9, 8); blank(2);
    hold(4'b0111, 8'hB0, 8); blank(2);
    n_vec++;
    if (fv_seen - fb !== 1) begin
      n_bad++; $display("FAIL errmask_fv: got %0d pulses want 1", fv_seen - fb);
    end
    n_vec++;
    if (digits !== 16'h3861) begin
      n_bad++; $display("FAIL errmask_digits: got %h want %h", digits, 16'h3861);
    end
  endtask

  task automatic test_back_to_back();
    int fb;
    fb = fv_seen;
    hold(4'b1110, 8'h99, 6);
    hold(4'b1101, 8'h92, 6);
    hold(4'b1011, 8'h82, 6);
    hold(4'b0111, 8'hF8, 6);
    blank(2);
    n_vec++;
    if (digits !== 16'h7654) begin
      n_bad++; $display("FAIL b2b_digits: got %h want %h", digits, 16'h7654);
    end
    n_vec++;
    if (fv_seen - fb !== 1) begin
      n_bad++; $display("FAIL b2b_fv: got %0d pulses want 1", fv_seen - fb);
    end
  endtask

  task automatic test_illegal();
    int eb;
    do_reset();
    eb = err_seen;
    hold(4'b1100, 8'hC0, 6);
    blank(2);
    n_vec++;
    if (err_seen - eb !== 1) begin
      n_bad++; $display("FAIL illegal_err: got %0d pulses want 1", err_seen - eb);
    end
    n_vec++;
    if (digits !== 16'hFFFF) begin
      n_bad++; $display("FAIL illegal_nocap: got %h want %h", digits, 16'hFFFF);
    end
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
    n_vec++;
    if (err_count !== 8'd1) begin
      n_bad++; $display("FAIL illegal_errcount: got %0d want 1", err_count);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    int fb;
    do_reset();
    fb = fv_seen;
    hold(4'b1110, 8'hC0, 8); blank(2);
    hold(4'b1101, 8'hF9, 8); blank(2);
    hold(4'b1011, 8'hA4, 8); blank(2);
    n_vec++;
    if (digits !== 16'hF210) begin
      n_bad++; $display("FAIL midreset_pre: got %h want %h", digits, 16'hF210);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    hold(4'b0111, 8'h99, 8);
    blank(2);
    n_vec++;
    if (fv_seen - fb !== 0) begin
      n_bad++; $display("FAIL midreset_fv: got %0d pulses want 0", fv_seen - fb);
    end
    n_vec++;
    if (digits !== 16'h4FFF) begin
      n_bad++; $display("FAIL midreset_digits: got %h want %h", digits, 16'h4FFF);
    end
  endtask

  initial begin
    reset    = 1'b1;
    anodes   = 4'hF;
    segments = 8'hFF;
    test_reset();
    test_basic();
    test_full_scan();
    test_glitch();
    test_unknown();
    test_err_mask();
    test_back_to_back();
    test_illegal();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
